cordic_quadrant_wrap: RTL
=========================

CORDIC_QUADRANT_WRAP -- requirements
Module: cordic_quadrant_wrap

Interface
REQ-001 SHALL have parameter TIMEOUT, default 40: the maximum number of RUN-state cycles to wait for core_done.
REQ-002 SHALL have parameter ARG_SCALE, default 25736: the value of pi/2 in 2.14 format.
REQ-003 clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  asserts that in_phase holds a request.
REQ-006 in_ready  output  1  the block accepts a request.
REQ-007 in_phase  input  16  unsigned full-circle phase; 65536 counts equal 2*pi.
REQ-008 core_reset  output  1  start pulse to the CORDIC core; that core's reset is synchronous.
REQ-009 core_argument  output  16  signed 2.14 reduced angle, in the range [0, pi/2).
REQ-010 core_sine, core_cos  input  16 each  signed core results.
REQ-011 core_done  input  1  the core has finished.
REQ-012 out_valid  output  1  out_sin, out_cos and out_err are valid.
REQ-013 out_ready  input  1  the consumer accepts the result.
REQ-014 out_sin, out_cos  output  16 each  signed, quadrant-corrected results.
REQ-015 out_err  output  1  the result was produced by a timeout, not by the core.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, RUN, FIX and HOLD.
REQ-017 in_ready SHALL be 1 only in IDLE.
- A request is accepted when in_valid and in_ready are both high.
- On acceptance: latch q = in_phase[15:14] and r = in_phase[13:0]; go to LOAD.
REQ-018 core_argument SHALL be registered on acceptance as (r * ARG_SCALE) >> 14.
- Multiply is unsigned, 30-bit product.
- Upper bits are zero-filled; the maximum value is 25734.
- core_argument stays stable until the next acceptance.
REQ-019 LOAD SHALL last exactly one cycle with core_reset = 1, then go to RUN.
- core_reset is 0 in every other state.
REQ-020 RUN SHALL ignore core_done on its first cycle.
- From the second RUN cycle on: core_done = 1 latches core_sine and core_cos into s and c, then goes to FIX.
REQ-021 A RUN cycle counter SHALL start at 0 on entry to RUN.
- When the counter reaches TIMEOUT-1 without core_done: set s = 0, c = 0, err = 1; go to FIX.
- core_done and timeout in the same cycle: core_done wins and err = 0.
REQ-022 FIX SHALL last one cycle and register the results by quadrant:
- q0: sin = s, cos = c
- q1: sin = c, cos = -s
- q2: sin = -s, cos = -c
- q3: sin = -c, cos = s
Then go to HOLD.
REQ-023 Negation SHALL saturate: -(-32768) yields 32767; all other values are exact two's complement.
REQ-024 HOLD SHALL drive out_valid = 1 with out_sin, out_cos and out_err stable.
- When out_ready = 1: go to IDLE, with out_valid low on the next cycle.
- out_ready is ignored outside HOLD.
REQ-025 in_valid SHALL be ignored in every state other than IDLE; there is no request queueing.
REQ-026 Latency SHALL be fixed: from the accept edge to the first out_valid cycle = 4 + N cycles.
- N is the RUN cycle index, counted from 0, on which core_done is taken.
- On timeout, the latency is 3 + TIMEOUT.

Reset
REQ-027 reset SHALL put the FSM in IDLE, which takes priority over all other events including mid-RUN and HOLD.
REQ-028 Reset values SHALL be:
- in_ready = 1
- core_reset = 0, core_argument = 0
- out_valid = 0, out_sin = 0, out_cos = 0, out_err = 0
- internal counter, q, s and c = 0
REQ-029 An in-flight result SHALL be discarded on reset, and no out_valid SHALL follow it.

Verification
REQ-030 Bench SHALL model the core as returning done 10 cycles after core_reset, with core_sine = S and core_cos = C.
REQ-031 in_phase = 0x0000, S = 0, C = 16384 -> core_argument = 0, out_sin = 0, out_cos = 16384, out_err = 0.
REQ-032 in_phase = 0x4000, S = 0, C = 16384 -> core_argument = 0, out_sin = 16384, out_cos = 0.
REQ-033 in_phase = 0x9000 -> core_argument = (0x1000 * 25736) >> 14 = 6434; S = 6270, C = 15137 -> out_sin = -6270, out_cos = -15137.
REQ-034 in_phase = 0xC000, S = -32768, C = 100 -> out_sin = -100, out_cos = -32768.
REQ-035 Core never asserts done -> out_valid after 3 + TIMEOUT = 43 cycles, with out_sin = 0, out_cos = 0, out_err = 1.
REQ-036 Hold out_ready = 0 for 5 cycles during HOLD, with a second in_valid pulse mid-RUN:
- outputs are stable throughout HOLD
- in_ready = 0 until the handshake completes
- the second request is dropped
- asserting reset in HOLD then clears out_valid on the next edge.

Source files
------------

// File: rtl/cordic_quadrant_wrap.sv
// ----------------------------------------------------------------------------
// cordic_quadrant_wrap
//
// Front end for a first-quadrant CORDIC sine/cosine core. A full-circle
// unsigned phase is split into a quadrant index and a residual angle. The
// residual is scaled into a signed 2.14 angle in [0, pi/2) for the core. The
// core is then started and its results are collected. They are rotated back
// into the requested quadrant, and the corrected pair is presented with a
// valid/ready handshake. A core that never finishes is covered by a RUN-state
// timeout, which returns zeros flagged with out_err.
//
// Parameters
//   TIMEOUT    maximum number of RUN cycles to wait for core_done
//   ARG_SCALE  pi/2 expressed in 2.14 fixed point
//
// Ports
//   clk            single clock, rising-edge active
//   reset          synchronous, active-high reset
//   in_valid       request present on in_phase
//   in_ready       block can accept a request (IDLE only)
//   in_phase       unsigned phase, 65536 counts per full turn
//   core_reset     one-cycle start pulse to the core (its reset is synchronous)
//   core_argument  reduced angle for the core, signed 2.14, held until next accept
//   core_sine      core sine result
//   core_cos       core cosine result
//   core_done      core has finished
//   out_valid      out_sin / out_cos / out_err hold a result
//   out_ready      consumer takes the result
//   out_sin        quadrant-corrected sine
//   out_cos        quadrant-corrected cosine
//   out_err        result came from a timeout rather than from the core
// ----------------------------------------------------------------------------
module cordic_quadrant_wrap #(
    parameter int TIMEOUT   = 40,
    parameter int ARG_SCALE = 25736
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        in_phase,
    output logic               core_reset,
    output logic [15:0]        core_argument,
    input  logic signed [15:0] core_sine,
    input  logic signed [15:0] core_cos,
    input  logic               core_done,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] out_sin,
    output logic signed [15:0] out_cos,
    output logic               out_err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        FIX,
        HOLD
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [1:0]         q;
    logic [CW-1:0]      run_cnt;
    logic signed [15:0] s;
    logic signed [15:0] c;
    logic               err;

    logic               accept;
    logic               done_take;
    logic               timeout_hit;
    logic [29:0]        arg_product;
    logic [15:0]        arg_scaled;
    logic signed [15:0] fix_sin;
    logic signed [15:0] fix_cos;

    // Two's complement negation that clips the single unrepresentable case.
    function automatic logic signed [15:0] neg_sat(input logic signed [15:0] v);
        if (v == 16'sh8000) begin
            return 16'sh7fff;
        end
        return -v;
    endfunction

    assign accept = (state == IDLE) && in_valid;

    // Residual (14 bits) times pi/2 (2.14) gives a 30-bit product; dropping 14
    // fraction bits leaves the 2.14 angle. The maximum, 25734, stays below pi/2,
    // so the top bit is always zero.
    assign arg_product = 30'(in_phase[13:0]) * 30'(ARG_SCALE);
    assign arg_scaled  = 16'(arg_product >> 14);

    // The first RUN cycle (run_cnt == 0) ignores core_done, because the core
    // may still show done from the previous job. A done on the final permitted
    // cycle beats the timeout.
    assign done_take   = (state == RUN) && (run_cnt != '0) && core_done;
    assign timeout_hit = (state == RUN) && (run_cnt == CW'(TIMEOUT - 1)) && !done_take;

    // Rotate the first-quadrant result back into the requested quadrant.
    always_comb begin
        // NOTE: every combinational output gets a default first, so that no
        // path through the case leaves it unassigned and infers a latch.
        fix_sin = s;
        fix_cos = c;
        case (q)
            2'd1: begin
                fix_sin = c;
                fix_cos = neg_sat(s);
            end
            2'd2: begin
                fix_sin = neg_sat(s);
                fix_cos = neg_sat(c);
            end
            2'd3: begin
                fix_sin = neg_sat(c);
                fix_cos = s;
            end
            default: begin
                fix_sin = s;
                fix_cos = c;
            end
        endcase
    end

    // Next-state and state-decoded handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        core_reset = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                core_reset = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                if (done_take || timeout_hit) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments, so every register
        // samples pre-edge values and the result is independent of evaluation order.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q             <= '0;
            core_argument <= '0;
            run_cnt       <= '0;
            s             <= '0;
            c             <= '0;
            err           <= 1'b0;
            out_sin       <= '0;
            out_cos       <= '0;
            out_err       <= 1'b0;
        end else begin
            if (accept) begin
                q             <= in_phase[15:14];
                core_argument <= arg_scaled;
            end

            // Counter is cleared in LOAD so it reads 0 on the first RUN cycle.
            if (state == LOAD) begin
                run_cnt <= '0;
            end else if ((state == RUN) && !done_take && !timeout_hit) begin
                run_cnt <= run_cnt + CW'(1);
            end

            if (done_take) begin
                s   <= core_sine;
                c   <= core_cos;
                err <= 1'b0;
            end else if (timeout_hit) begin
                s   <= '0;
                c   <= '0;
                err <= 1'b1;
            end

            // Results are registered once in FIX and held unchanged through HOLD.
            if (state == FIX) begin
                out_sin <= fix_sin;
                out_cos <= fix_cos;
                out_err <= err;
            end
        end
    end

endmodule
